// File: rtl/mips_multicycle_ctrl_if.sv
// Memory handshake bundle between the multicycle controller and the shared
// instruction/data memory. The controller is the master: it requests an
// access, selects the address source and strobes writes; the memory answers
// with mem_ready in the cycle the access completes.
interface mips_multicycle_ctrl_if;
    logic mem_req;    // access requested this cycle
    logic iord;       // 0 = PC address, 1 = ALUOut address
    logic memwrite;   // write strobe, held for the whole store
    logic mem_ready;  // memory completes the current access this cycle

    modport master (
        output mem_req,
        output iord,
        output memwrite,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  iord,
        input  memwrite,
        output mem_ready
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit.
// Sequences each instruction through fetch/decode/execute/memory/writeback
// states and drives the shared-ALU / shared-memory datapath. Memory accesses
// use a ready handshake with a bounded wait (WAIT_MAX stalled cycles); a
// timeout raises bus_err and restarts at FETCH with no PC or IR update so
// the same PC is retried. Undecodable opcodes or R-type funcs pulse
// illegal_op and return to FETCH.
// Optional feature: define MC_CTRL_BNE_EN to decode bne (opcode 000101)
// through the BRANCH state with an inverted take condition.
module mips_multicycle_ctrl #(
    parameter int WAIT_MAX  = 15,
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           func,
    input  logic                 zero,
    mips_multicycle_ctrl_if.master mem,
    output logic                 irwrite,
    output logic                 pcwrite,
    output logic                 branch,
    output logic                 pcen,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic [3:0]           state_o,
    output logic                 illegal_op,
    output logic                 bus_err
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_MUL = 3'b101;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;

    logic       timeout_s;
    logic       mem_state_s;
    logic       take_s;
    logic       mem_req_s;
    logic       iord_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic       pcwrite_s;
    logic       branch_s;
    logic       regdst_s;
    logic       memtoreg_s;
    logic       regwrite_s;
    logic       alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] pcsrc_s;
    logic [2:0] alu_s;
    logic       illegal_s;
    logic       bus_err_s;

    // A stalled access has exhausted its budget when the counter hits the limit.
    assign timeout_s = (wait_cnt == WAIT_LIMIT);

    // State register; reset parks the sequencer in FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Wait counter: counts stalled cycles inside a memory state and is zero
    // everywhere else, so it is already clear on entry to FETCH/MEMRD/MEMWR.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (mem_state_s && !mem.mem_ready && !timeout_s) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Next-state and Moore output decode, plus the transition pulses.
    always_comb begin
        next_state  = state;
        mem_state_s = 1'b0;
        take_s      = 1'b0;
        mem_req_s   = 1'b0;
        iord_s      = 1'b0;
        memwrite_s  = 1'b0;
        irwrite_s   = 1'b0;
        pcwrite_s   = 1'b0;
        branch_s    = 1'b0;
        regdst_s    = 1'b0;
        memtoreg_s  = 1'b0;
        regwrite_s  = 1'b0;
        alusrca_s   = 1'b0;
        alusrcb_s   = 2'b00;
        pcsrc_s     = 2'b00;
        alu_s       = ALU_ADD;
        illegal_s   = 1'b0;
        bus_err_s   = 1'b0;
        case (state)
            FETCH: begin
                mem_state_s = 1'b1;
                mem_req_s   = 1'b1;
                alusrcb_s   = 2'b01;
                if (mem.mem_ready) begin
                    irwrite_s  = 1'b1;
                    pcwrite_s  = 1'b1;
                    next_state = DECODE;
                end else if (timeout_s) begin
                    bus_err_s  = 1'b1;
                    next_state = FETCH;
                end else begin
                    next_state = FETCH;
                end
            end
            DECODE: begin
                alusrcb_s = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXEC;
`ifdef MC_CTRL_BNE_EN
                    OP_BEQ, OP_BNE: next_state = BRANCH;
`else
                    OP_BEQ:       next_state = BRANCH;
`endif
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default: begin
                        illegal_s  = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                if (opcode == OP_SW) begin
                    next_state = MEMWR;
                end else begin
                    next_state = MEMRD;
                end
            end
            MEMRD: begin
                mem_state_s = 1'b1;
                mem_req_s   = 1'b1;
                iord_s      = 1'b1;
                if (mem.mem_ready) begin
                    next_state = MEMWB;
                end else if (timeout_s) begin
                    bus_err_s  = 1'b1;
                    next_state = FETCH;
                end else begin
                    next_state = MEMRD;
                end
            end
            MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                mem_state_s = 1'b1;
                mem_req_s   = 1'b1;
                iord_s      = 1'b1;
                memwrite_s  = 1'b1;
                if (mem.mem_ready) begin
                    next_state = FETCH;
                end else if (timeout_s) begin
                    bus_err_s  = 1'b1;
                    next_state = FETCH;
                end else begin
                    next_state = MEMWR;
                end
            end
            EXEC: begin
                alusrca_s  = 1'b1;
                next_state = ALUWB;
                case (func)
                    6'b100000: alu_s = ALU_ADD;
                    6'b100010: alu_s = ALU_SUB;
                    6'b100100: alu_s = ALU_AND;
                    6'b100101: alu_s = ALU_OR;
                    6'b101010: alu_s = ALU_SLT;
                    6'b011100: alu_s = ALU_MUL;
                    default: begin
                        alu_s      = ALU_ADD;
                        illegal_s  = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            ALUWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alusrca_s = 1'b1;
                alu_s     = ALU_SUB;
                pcsrc_s   = 2'b01;
                branch_s  = 1'b1;
`ifdef MC_CTRL_BNE_EN
                take_s    = zero ^ (opcode == OP_BNE);
`else
                take_s    = zero;
`endif
                next_state = FETCH;
            end
            ADDIEX: begin
                alusrca_s  = 1'b1;
                alusrcb_s  = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                regwrite_s = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                pcsrc_s    = 2'b10;
                pcwrite_s  = 1'b1;
                next_state = FETCH;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    // While reset is high every strobe is suppressed and the remaining
    // selects show FETCH values, whatever the state register still holds.
    assign mem.mem_req  = reset ? 1'b0 : mem_req_s;
    assign mem.iord     = reset ? 1'b0 : iord_s;
    assign mem.memwrite = reset ? 1'b0 : memwrite_s;
    assign irwrite      = reset ? 1'b0 : irwrite_s;
    assign pcwrite      = reset ? 1'b0 : pcwrite_s;
    assign branch       = reset ? 1'b0 : branch_s;
    assign pcen         = reset ? 1'b0 : (pcwrite_s | (branch_s & take_s));
    assign regdst       = reset ? 1'b0 : regdst_s;
    assign memtoreg     = reset ? 1'b0 : memtoreg_s;
    assign regwrite     = reset ? 1'b0 : regwrite_s;
    assign alusrca      = reset ? 1'b0 : alusrca_s;
    assign alusrcb      = reset ? 2'b01 : alusrcb_s;
    assign pcsrc        = reset ? 2'b00 : pcsrc_s;
    assign alucontrol   = reset ? ALUCTRL_W'(ALU_ADD) : ALUCTRL_W'(alu_s);
    assign state_o      = reset ? 4'd0 : state;
    assign illegal_op   = reset ? 1'b0 : illegal_s;
    assign bus_err      = reset ? 1'b0 : bus_err_s;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. A reference model expands
// each instruction into the expected cycle-by-cycle trace (inputs to drive
// and outputs to expect) from the instruction's CPI, memory stall schedule
// and wait budget; each test task then replays that trace on the DUT.
module tb_mips_multicycle_ctrl;

    localparam int WAIT_MAX  = 4;
    localparam int ALUCTRL_W = 4;

`ifdef MC_CTRL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    // expected-output bits in the sig field
    localparam logic [12:0] S_MREQ = 13'h1000;
    localparam logic [12:0] S_IORD = 13'h0800;
    localparam logic [12:0] S_MWR  = 13'h0400;
    localparam logic [12:0] S_IRW  = 13'h0200;
    localparam logic [12:0] S_PCW  = 13'h0100;
    localparam logic [12:0] S_BR   = 13'h0080;
    localparam logic [12:0] S_PCEN = 13'h0040;
    localparam logic [12:0] S_RDST = 13'h0020;
    localparam logic [12:0] S_M2R  = 13'h0010;
    localparam logic [12:0] S_RW   = 13'h0008;
    localparam logic [12:0] S_ASA  = 13'h0004;
    localparam logic [12:0] S_ILL  = 13'h0002;
    localparam logic [12:0] S_BERR = 13'h0001;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        zr;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [3:0]  st;
        logic [12:0] sig;
        logic [1:0]  srcb;
        logic [1:0]  pcs;
        logic [3:0]  alu;
    } cyc_t;

    logic clk;
    logic reset;
    logic [5:0] opcode;
    logic [5:0] func;
    logic zero;
    logic irwrite, pcwrite, branch, pcen, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic [3:0] state_o;
    logic illegal_op, bus_err;

    mips_multicycle_ctrl_if mem_bus();

    mips_multicycle_ctrl #(.WAIT_MAX(WAIT_MAX), .ALUCTRL_W(ALUCTRL_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
        .mem(mem_bus),
        .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch), .pcen(pcen),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .state_o(state_o),
        .illegal_op(illegal_op), .bus_err(bus_err)
    );

    int checks = 0;
    int fails  = 0;
    cyc_t exp_q[$];
    logic [5:0] cur_op = 6'd0;
    logic [5:0] cur_fn = 6'd0;
    logic cur_rst = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] pick_func(int i);
        case (i)
            0: return 6'b100000;
            1: return 6'b100010;
            2: return 6'b100100;
            3: return 6'b100101;
            4: return 6'b101010;
            default: return 6'b011100;
        endcase
    endfunction

    task automatic push(input logic rdy, input logic zr, input logic [3:0] st,
                        input logic [12:0] sig, input logic [1:0] srcb,
                        input logic [1:0] pcs, input logic [2:0] alu);
        cyc_t c;
        c.rst = cur_rst; c.rdy = rdy; c.zr = zr; c.op = cur_op; c.fn = cur_fn;
        c.st = st; c.sig = sig; c.srcb = srcb; c.pcs = pcs; c.alu = {1'b0, alu};
        exp_q.push_back(c);
    endtask

    // One memory access: 'stalls' not-ready cycles, then ready, unless the
    // wait budget runs out first.
    task automatic mem_access(input logic [3:0] st, input logic [12:0] base,
                              input logic [1:0] srcb, input logic [12:0] on_ready,
                              input int stalls, output bit ok);
        ok = 1'b0;
        for (int c = 0; c <= stalls; c++) begin
            if (c == stalls) begin
                push(1'b1, rb(), st, base | on_ready, srcb, 2'b00, 3'b010);
                ok = 1'b1;
            end else if (c == WAIT_MAX) begin
                push(1'b0, rb(), st, base | S_BERR, srcb, 2'b00, 3'b010);
                return;
            end else begin
                push(1'b0, rb(), st, base, srcb, 2'b00, 3'b010);
            end
        end
    endtask

    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic zr, input int fstall, input int dstall);
        bit ok;
        bit legal;
        bit fvalid;
        logic [2:0] alu;
        cur_op = op; cur_fn = fn;
        mem_access(4'd0, S_MREQ, 2'b01, S_IRW | S_PCW | S_PCEN, fstall, ok);
        if (!ok) return;
        legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ) ||
                (op == OP_ADDI) || (op == OP_J) || (BNE_EN && op == OP_BNE);
        push(rb(), rb(), 4'd1, legal ? 13'd0 : S_ILL, 2'b11, 2'b00, 3'b010);
        if (!legal) return;
        if (op == OP_LW || op == OP_SW) begin
            push(rb(), rb(), 4'd2, S_ASA, 2'b10, 2'b00, 3'b010);
            if (op == OP_LW) begin
                mem_access(4'd3, S_MREQ | S_IORD, 2'b00, 13'd0, dstall, ok);
                if (ok) push(rb(), rb(), 4'd4, S_M2R | S_RW, 2'b00, 2'b00, 3'b010);
            end else begin
                mem_access(4'd5, S_MREQ | S_IORD | S_MWR, 2'b00, 13'd0, dstall, ok);
            end
        end else if (op == OP_R) begin
            fvalid = 1'b1;
            case (fn)
                6'b100000: alu = 3'b010;
                6'b100010: alu = 3'b110;
                6'b100100: alu = 3'b000;
                6'b100101: alu = 3'b001;
                6'b101010: alu = 3'b111;
                6'b011100: alu = 3'b101;
                default: begin alu = 3'b010; fvalid = 1'b0; end
            endcase
            push(rb(), rb(), 4'd6, S_ASA | (fvalid ? 13'd0 : S_ILL), 2'b00, 2'b00, alu);
            if (fvalid) push(rb(), rb(), 4'd7, S_RDST | S_RW, 2'b00, 2'b00, 3'b010);
        end else if (op == OP_BEQ || op == OP_BNE) begin
            push(rb(), zr, 4'd8, S_ASA | S_BR | (((op == OP_BNE) ^ zr) ? S_PCEN : 13'd0),
                 2'b00, 2'b01, 3'b110);
        end else if (op == OP_ADDI) begin
            push(rb(), rb(), 4'd9, S_ASA, 2'b10, 2'b00, 3'b010);
            push(rb(), rb(), 4'd10, S_RW, 2'b00, 2'b00, 3'b010);
        end else begin
            push(rb(), rb(), 4'd11, S_PCW | S_PCEN, 2'b00, 2'b10, 3'b010);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and sample 2 ns later.
    task automatic step(input cyc_t e, output cyc_t o);
        @(negedge clk);
        reset = e.rst; mem_bus.mem_ready = e.rdy; zero = e.zr;
        opcode = e.op; func = e.fn;
        #2;
        o = e;
        o.st   = state_o;
        o.sig  = {mem_bus.mem_req, mem_bus.iord, mem_bus.memwrite, irwrite, pcwrite,
                  branch, pcen, regdst, memtoreg, regwrite, alusrca, illegal_op, bus_err};
        o.srcb = alusrcb;
        o.pcs  = pcsrc;
        o.alu  = alucontrol;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cyc_t e, o;
        int n = 0;
        cur_rst = 1'b1;
        push(1'b1, 1'b0, 4'd0, 13'd0, 2'b01, 2'b00, 3'b010);
        push(1'b1, 1'b0, 4'd0, 13'd0, 2'b01, 2'b00, 3'b010);
        cur_rst = 1'b0;
        gen_instr(OP_J, 6'd0, 1'b0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(e, o); checks++; n++;
            if (o !== e) begin
                fails++;
                $display("FAIL reset cyc %0d: got st=%0d sig=%b srcb=%b pcs=%b alu=%h, expected st=%0d sig=%b srcb=%b pcs=%b alu=%h",
                         n, o.st, o.sig, o.srcb, o.pcs, o.alu, e.st, e.sig, e.srcb, e.pcs, e.alu);
            end
        end
    endtask

    task automatic test_lw_sw();
        cyc_t e, o;
        int n = 0;
        gen_instr(OP_LW, 6'd0, 1'b0, 0, 0);
        gen_instr(OP_SW, 6'd0, 1'b0, 0, 3);
        gen_instr(OP_LW, 6'd0, 1'b0, 2, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(e, o); checks++; n++;
            if (o !== e) begin
                fails++;
                $display("FAIL lw_sw cyc %0d: got st=%0d sig=%b srcb=%b pcs=%b alu=%h, expected st=%0d sig=%b srcb=%b pcs=%b alu=%h",
                         n, o.st, o.sig, o.srcb, o.pcs, o.alu, e.st, e.sig, e.srcb, e.pcs, e.alu);
            end
        end
    endtask

    task automatic test_rtype_branch();
        cyc_t e, o;
        int n = 0;
        gen_instr(OP_R, 6'b100010, 1'b0, 0, 0);
        gen_instr(OP_R, 6'b111111, 1'b0, 0, 0);
        gen_instr(OP_BEQ, 6'd0, 1'b1, 0, 0);
        gen_instr(OP_BEQ, 6'd0, 1'b0, 0, 0);
        gen_instr(OP_ADDI, 6'd0, 1'b0, 0, 0);
        gen_instr(6'b111111, 6'd0, 1'b0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(e, o); checks++; n++;
            if (o !== e) begin
                fails++;
                $display("FAIL rtype_branch cyc %0d: got st=%0d sig=%b srcb=%b pcs=%b alu=%h, expected st=%0d sig=%b srcb=%b pcs=%b alu=%h",
                         n, o.st, o.sig, o.srcb, o.pcs, o.alu, e.st, e.sig, e.srcb, e.pcs, e.alu);
            end
        end
    endtask

    task automatic test_timeout();
        cyc_t e, o;
        int n = 0;
        gen_instr(OP_J, 6'd0, 1'b0, WAIT_MAX + 1, 0);       // fetch timeout
        gen_instr(OP_BNE, 6'd0, 1'b1, 0, 0);                // bne, zero=1
        gen_instr(OP_BNE, 6'd0, 1'b0, 0, 0);                // bne, zero=0
        gen_instr(OP_ADDI, 6'd0, 1'b0, WAIT_MAX, 0);        // ready wins at limit
        gen_instr(OP_LW, 6'd0, 1'b0, 0, WAIT_MAX);          // ready wins in MEMRD
        gen_instr(OP_LW, 6'd0, 1'b0, 0, WAIT_MAX + 2);      // MEMRD timeout
        gen_instr(OP_SW, 6'd0, 1'b0, 0, WAIT_MAX + 1);      // MEMWR timeout
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(e, o); checks++; n++;
            if (o !== e) begin
                fails++;
                $display("FAIL timeout cyc %0d: got st=%0d sig=%b srcb=%b pcs=%b alu=%h, expected st=%0d sig=%b srcb=%b pcs=%b alu=%h",
                         n, o.st, o.sig, o.srcb, o.pcs, o.alu, e.st, e.sig, e.srcb, e.pcs, e.alu);
            end
        end
    endtask

    task automatic test_reset_abort();
        cyc_t e, o;
        int n = 0;
        gen_instr(OP_LW, 6'd0, 1'b0, 0, 3);
        // keep fetch, decode, memadr and two MEMRD stalls only
        while (exp_q.size() > 5) void'(exp_q.pop_back());
        cur_rst = 1'b1;
        push(1'b1, 1'b0, 4'd0, 13'd0, 2'b01, 2'b00, 3'b010);
        push(1'b1, 1'b1, 4'd0, 13'd0, 2'b01, 2'b00, 3'b010);
        cur_rst = 1'b0;
        gen_instr(OP_R, 6'b100101, 1'b0, 1, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(e, o); checks++; n++;
            if (o !== e) begin
                fails++;
                $display("FAIL reset_abort cyc %0d: got st=%0d sig=%b srcb=%b pcs=%b alu=%h, expected st=%0d sig=%b srcb=%b pcs=%b alu=%h",
                         n, o.st, o.sig, o.srcb, o.pcs, o.alu, e.st, e.sig, e.srcb, e.pcs, e.alu);
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc_t e, o;
        int n = 0;
        logic [5:0] op, fn;
        int fs, ds;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 8))
                0: op = OP_LW;
                1: op = OP_SW;
                2, 8: op = OP_R;
                3: op = OP_BEQ;
                4: op = OP_BNE;
                5: op = OP_ADDI;
                6: op = OP_J;
                default: op = 6'($urandom_range(0, 63));
            endcase
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : pick_func(int'($urandom_range(0, 5)));
            fs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
            ds = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
            gen_instr(op, fn, rb(), fs, ds);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(e, o); checks++; n++;
            if (o !== e) begin
                fails++;
                $display("FAIL back_to_back cyc %0d: got st=%0d sig=%b srcb=%b pcs=%b alu=%h, expected st=%0d sig=%b srcb=%b pcs=%b alu=%h",
                         n, o.st, o.sig, o.srcb, o.pcs, o.alu, e.st, e.sig, e.srcb, e.pcs, e.alu);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_bus.mem_ready = 1'b0;
        zero = 1'b0;
        opcode = 6'd0;
        func = 6'd0;
        test_reset();
        test_lw_sw();
        test_rtype_branch();
        test_timeout();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
